// File: rtl/sine_obstacle_scroller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sine_obstacle_scroller_pkg : game states and quarter-wave sine amplitudes
// Rev 1.0
// ----------------------------------------------------------------------------
package sine_obstacle_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_CRASH  = 2'b11
  } state_e;

  localparam int SINE_W   = 8;
  localparam int SINE_MID = 128;
  // Finest quarter table resolution: 8 steps per quarter (LUT_BITS up to 5).
  localparam int QTR_LOG2_MAX = 3;

  // round(127*sin(pi/2 * idx/8)) for idx = 0..8
  function automatic logic [6:0] quarter_amp(input logic [3:0] idx);
    case (idx)
      4'd0:    quarter_amp = 7'd0;
      4'd1:    quarter_amp = 7'd25;
      4'd2:    quarter_amp = 7'd49;
      4'd3:    quarter_amp = 7'd71;
      4'd4:    quarter_amp = 7'd90;
      4'd5:    quarter_amp = 7'd106;
      4'd6:    quarter_amp = 7'd117;
      4'd7:    quarter_amp = 7'd125;
      default: quarter_amp = 7'd127;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_lut_param.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sine_lut_param : combinational sine sample, quarter-wave table with mirroring
// Rev 1.0  (LUT_BITS valid range 3..5)
// ----------------------------------------------------------------------------
module sine_lut_param
  import sine_obstacle_scroller_pkg::*;
#(
  parameter int LUT_BITS = 4
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [SINE_W-1:0]   sample
);

  localparam int                QB          = LUT_BITS - 2;
  localparam int                STRIDE_LOG2 = QTR_LOG2_MAX - QB;
  localparam logic [QB:0]       QTR         = (QB+1)'(1 << QB);
  localparam logic [SINE_W-1:0] MID         = SINE_W'(SINE_MID);

  logic [1:0]    quad;
  logic [QB-1:0] q;
  logic [QB:0]   qi;
  logic [3:0]    tab_idx;
  logic [6:0]    amp;

  assign quad = idx[LUT_BITS-1 -: 2];
  assign q    = idx[QB-1:0];

  always_comb begin
    // Odd quadrants run the quarter table backwards, upper half is negated.
    qi      = quad[0] ? (QTR - {1'b0, q}) : {1'b0, q};
    tab_idx = 4'(qi) << STRIDE_LOG2;
    amp     = quarter_amp(tab_idx);
    sample  = quad[1] ? (MID - {1'b0, amp}) : (MID + {1'b0, amp});
  end

endmodule
`default_nettype wire

// File: rtl/sine_obstacle_scroller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sine_obstacle_scroller : N-lane scrolling sine obstacles, run/pause/crash FSM
// Rev 1.0
// ----------------------------------------------------------------------------
module sine_obstacle_scroller
  import sine_obstacle_scroller_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int SCREEN_W   = 640,
  parameter int BAR_LOG2   = 5,
  parameter int VISIBLE_W  = 25,
  parameter int LUT_BITS   = 4,
  parameter int AMP_SHIFT  = 2,
  parameter int HEIGHT     = 60,
  parameter int LANE_Y0    = 100,
  parameter int LANE_PITCH = 160,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 7,
  parameter int RAMP_LOG2  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             pause,
  input  logic             player_px,
  output logic [LANES-1:0] lane_draw,
  output logic             draw_any,
  output logic             hit,
  output logic [1:0]       state,
  output logic [2:0]       speed
);

  localparam logic [10:0]         SW11    = 11'(SCREEN_W);
  localparam logic [10:0]         SW2_11  = 11'(2 * SCREEN_W);
  localparam logic [10:0]         HGT11   = 11'(HEIGHT);
  localparam logic [BAR_LOG2-1:0] VIS_C   = BAR_LOG2'(VISIBLE_W);
  localparam logic [2:0]          SPD_INI = 3'(SPEED_INIT);
  localparam logic [2:0]          SPD_MAX = 3'(SPEED_MAX);

  state_e                    state_q, state_d;
  logic [LANES-1:0][9:0]     off_q, off_d, next_off;
  logic [2:0]                speed_q, speed_d;
  logic [RAMP_LOG2-1:0]      frame_cnt_q, frame_cnt_d;
  logic                      hit_q, hit_d;
  logic [LANES-1:0]          lane_draw_q, lane_draw_d;
  logic                      draw_any_q, draw_any_d;
  logic [LANES-1:0]          on_w;
  logic                      collision;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [10:0]          raw, sx, top, adv;
    logic [SINE_W-1:0]    sample;
    logic [BAR_LOG2-1:0]  col;
    logic [LUT_BITS-1:0]  pos;
    logic                 unused_sx_bits;

    assign raw = {1'b0, pix_x} + {1'b0, off_q[l]};
    // pix_x may run past the visible width during blanking, so fold up to twice.
    assign sx  = (raw >= SW2_11) ? (raw - SW2_11) :
                 (raw >= SW11)   ? (raw - SW11)   : raw;
    assign col = sx[BAR_LOG2-1:0];
    assign pos = sx[BAR_LOG2+LUT_BITS-1:BAR_LOG2];
    assign unused_sx_bits = ^sx[10:BAR_LOG2+LUT_BITS];

    sine_lut_param #(.LUT_BITS(LUT_BITS)) u_lut (
      .idx    (pos),
      .sample (sample)
    );

    assign top     = 11'(LANE_Y0 + l * LANE_PITCH) + 11'(sample >> AMP_SHIFT);
    assign on_w[l] = (col < VIS_C) && ({1'b0, pix_y} >= top) &&
                     ({1'b0, pix_y} < (top + HGT11));

    assign adv         = {1'b0, off_q[l]} + {8'd0, speed_q} + 11'(l);
    assign next_off[l] = (adv >= SW11) ? 10'(adv - SW11) : adv[9:0];
  end

  assign collision = (state_q == ST_RUN) && player_px && (|on_w);

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    hit_d       = hit_q;
    lane_draw_d = on_w;
    draw_any_d  = |on_w;
    case (state_q)
      ST_IDLE, ST_CRASH: begin
        if (start) begin
          state_d     = ST_RUN;
          off_d       = '0;
          hit_d       = 1'b0;
          frame_cnt_d = '0;
          speed_d     = SPD_INI;
        end
      end
      ST_RUN: begin
        if (collision) begin
          hit_d   = 1'b1;
          state_d = ST_CRASH;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (frame_tick) begin
          off_d       = next_off;
          frame_cnt_d = frame_cnt_q + 1'b1;
          if ((&frame_cnt_q) && (speed_q < SPD_MAX)) begin
            speed_d = speed_q + 3'd1;
          end
        end
      end
      ST_PAUSED: begin
        if (pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      off_q       <= '0;
      speed_q     <= SPD_INI;
      frame_cnt_q <= '0;
      hit_q       <= 1'b0;
      lane_draw_q <= '0;
      draw_any_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
      hit_q       <= hit_d;
      lane_draw_q <= lane_draw_d;
      draw_any_q  <= draw_any_d;
    end
  end

  assign lane_draw = lane_draw_q;
  assign draw_any  = draw_any_q;
  assign hit       = hit_q;
  assign state     = state_q;
  assign speed     = speed_q;

endmodule
`default_nettype wire
